// File: rtl/instruction_loader.sv
// UART byte-stream program loader: assembles big-endian words into instruction RAM and holds the CPU in reset until loaded.
// Optional trailing checksum byte and sticky error flag enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {ST_IDLE, ST_COUNT, ST_DATA, ST_CHECK, ST_DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  count_reg, count_next;
  logic [7:0]  widx_reg, widx_next;
  logic [1:0]  bidx_reg, bidx_next;
  logic [23:0] asm_reg, asm_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        hold_reg, hold_next;
  logic        done_reg, done_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg, csum_next;
  logic        error_reg, error_next;
`endif

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    widx_next  = widx_reg;
    bidx_next  = bidx_reg;
    asm_next   = asm_reg;
    we_next    = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    done_next  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_next  = csum_reg;
    error_next = error_reg;
`endif
    if (rx_valid) begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (rx_data == SYNC_BYTE) begin
            state_next = ST_COUNT;
            widx_next  = 8'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_next  = 8'd0;
            error_next = 1'b0;
`endif
          end
        end
        ST_COUNT: begin
          count_next = rx_data;
          bidx_next  = 2'd0;
          state_next = ST_DATA;
`ifdef LOADER_CHECKSUM_EN
          csum_next  = rx_data;
`endif
        end
        ST_DATA: begin
          asm_next  = {asm_reg[15:0], rx_data};
          bidx_next = bidx_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_next = csum_reg ^ rx_data;
`endif
          if (bidx_reg == 2'd3) begin
            we_next    = 1'b1;
            addr_next  = ADDR_BASE + {22'd0, widx_reg, 2'b00};
            wdata_next = {asm_reg, rx_data};
            widx_next  = widx_reg + 8'd1;
            // count 0 means 256 words: 0 - 1 wraps to 255
            if (widx_reg == count_reg - 8'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_next = ST_CHECK;
`else
              state_next = ST_DONE;
              done_next  = 1'b1;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_data == csum_reg) begin
            state_next = ST_DONE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_IDLE;
            error_next = 1'b1;
          end
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end
    hold_next = (state_next != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= 8'd0;
      widx_reg  <= 8'd0;
      bidx_reg  <= 2'd0;
      asm_reg   <= 24'd0;
      we_reg    <= 1'b0;
      addr_reg  <= ADDR_BASE;
      wdata_reg <= 32'd0;
      hold_reg  <= 1'b1;
      done_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_reg  <= 8'd0;
      error_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      widx_reg  <= widx_next;
      bidx_reg  <= bidx_next;
      asm_reg   <= asm_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      hold_reg  <= hold_next;
      done_reg  <= done_next;
`ifdef LOADER_CHECKSUM_EN
      csum_reg  <= csum_next;
      error_reg <= error_next;
`endif
    end
  end

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign cpu_hold  = hold_reg;
  assign done      = done_reg;
`ifdef LOADER_CHECKSUM_EN
  assign error     = error_reg;
`else
  assign error     = 1'b0;
`endif

endmodule
